// File: rtl/i_issue_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i_issue_pkg
//  Description : Shared constants, funct3 encoding and instruction field
//                layout for the OP-IMM issue path.
//  Revision    : 1.0 - initial release
// ============================================================================
package i_issue_pkg;

   localparam logic [6:0]  OPCODE_OP_IMM = 7'b0010011;
   localparam logic [31:0] NOP_INSTR     = 32'h00000013;   // addi x0,x0,0
   localparam logic [6:0]  FUNCT7_ZERO   = 7'b0000000;
   localparam logic [6:0]  FUNCT7_SRA    = 7'b0100000;

   typedef enum logic [2:0] {
      ADDI      = 3'b000,
      SLLI      = 3'b001,
      SLTI      = 3'b010,
      SLTIU     = 3'b011,
      XORI      = 3'b100,
      SRLI_SRAI = 3'b101,
      ORI       = 3'b110,
      ANDI      = 3'b111
   } funct3_e;

   typedef struct packed {
      logic [11:0] imm12;
      logic [4:0]  rs1;
      funct3_e     funct3;
      logic [4:0]  rd;
      logic [6:0]  opcode;
   } i_fields_t;

   // Sign-extend the 12-bit I-type immediate to 32 bits.
   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage
`default_nettype wire

// File: rtl/i_type_issue_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i_type_issue_if
//  Description : Instruction handshake, ALU operand/result bus and writeback
//                observation signals of the OP-IMM issue block.
//                master = instruction source / ALU side, slave = issue block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i_type_issue_if #(
   parameter int XLEN = 32
);
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr_word;
   logic [31:0]     alu_instr;
   logic [XLEN-1:0] alu_in1;
   logic [XLEN-1:0] alu_imm;
   logic [XLEN-1:0] alu_result;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   modport master (
      output instr_valid, instr_word, alu_result,
      input  instr_ready, alu_instr, alu_in1, alu_imm, wb_valid, wb_rd, wb_data
   );

   modport slave (
      input  instr_valid, instr_word, alu_result,
      output instr_ready, alu_instr, alu_in1, alu_imm, wb_valid, wb_rd, wb_data
   );
endinterface
`default_nettype wire

// File: rtl/i_issue_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i_issue_regfile
//  Description : REG_COUNT x XLEN architectural register file. Two
//                combinational read ports (rs1, debug), one synchronous
//                write port. x0 is never written and always reads zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module i_issue_regfile #(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32
) (
   input  wire logic                         clk,
   input  wire logic                         rst,
   input  wire logic [$clog2(REG_COUNT)-1:0] i_rs1_addr,
   output logic      [XLEN-1:0]              o_rs1_data,
   input  wire logic [$clog2(REG_COUNT)-1:0] i_dbg_addr,
   output logic      [XLEN-1:0]              o_dbg_data,
   input  wire logic                         i_we,
   input  wire logic [$clog2(REG_COUNT)-1:0] i_waddr,
   input  wire logic [XLEN-1:0]              i_wdata
);

   logic [XLEN-1:0] r_regs [REG_COUNT];

   // Register storage; writes aimed at x0 are dropped so entry 0 stays zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Combinational reads; x0 forced to zero explicitly.
   always_comb begin
      o_rs1_data = (i_rs1_addr == '0) ? '0 : r_regs[i_rs1_addr];
      o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
   end

endmodule
`default_nettype wire

// File: rtl/i_type_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i_type_issue
//  Description : Decode / legality / regfile / writeback shell of the OP-IMM
//                path. Registers {instr, rs1 value, sign-extended imm} toward
//                a combinational ALU and writes its result back one cycle
//                later.
//                Macro I_ISSUE_FORWARD_EN: when defined, a read of the rd
//                currently in the ALU stage is forwarded from alu_result;
//                otherwise instr_ready drops for one cycle (RAW stall).
//  Revision    : 1.0 - initial release
// ============================================================================
module i_type_issue
   import i_issue_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32,
   parameter int ILL_CNT_W = 8
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   i_type_issue_if.slave              bus,
   output logic                       illegal,
   output logic      [ILL_CNT_W-1:0]  illegal_cnt,
   input  wire logic [4:0]            dbg_addr,
   output logic      [XLEN-1:0]       dbg_data
);

   i_fields_t            w_f;
   logic [6:0]           w_funct7;
   logic                 w_legal;
   logic [4:0]           w_wb_rd;
   logic                 w_raw;
   logic                 w_ready;
   logic                 w_xfer;
   logic [XLEN-1:0]      w_rf_rs1;
   logic [XLEN-1:0]      w_rs1_val;

   logic [31:0]          r_alu_instr;
   logic [XLEN-1:0]      r_alu_in1;
   logic [XLEN-1:0]      r_alu_imm;
   logic                 r_wb_valid;
   logic                 r_illegal;
   logic [ILL_CNT_W-1:0] r_ill_cnt;

   assign w_f      = i_fields_t'(bus.instr_word);
   assign w_funct7 = w_f.imm12[11:5];
   assign w_wb_rd  = r_alu_instr[11:7];

   // Legality: OP-IMM opcode, and shifts must carry a valid funct7.
   always_comb begin
      w_legal = 1'b0;
      if (w_f.opcode == OPCODE_OP_IMM) begin
         case (w_f.funct3)
            SLLI:      w_legal = (w_funct7 == FUNCT7_ZERO);
            SRLI_SRAI: w_legal = (w_funct7 == FUNCT7_ZERO) || (w_funct7 == FUNCT7_SRA);
            default:   w_legal = 1'b1;
         endcase
      end
   end

   // RAW hazard: incoming rs1 names the register the ALU stage writes this cycle.
   assign w_raw = r_wb_valid && (w_f.rs1 == w_wb_rd) && (w_f.rs1 != 5'd0);

   // Operand source and ready: forward from the ALU, or hold off one cycle.
   always_comb begin
`ifdef I_ISSUE_FORWARD_EN
      w_ready   = 1'b1;
      w_rs1_val = w_raw ? bus.alu_result : w_rf_rs1;
`else
      w_ready   = ~w_raw;
      w_rs1_val = w_rf_rs1;
`endif
   end

   assign w_xfer = bus.instr_valid && w_ready;

   i_issue_regfile #(
      .XLEN      (XLEN),
      .REG_COUNT (REG_COUNT)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .i_rs1_addr (w_f.rs1),
      .o_rs1_data (w_rf_rs1),
      .i_dbg_addr (dbg_addr),
      .o_dbg_data (dbg_data),
      .i_we       (r_wb_valid),
      .i_waddr    (w_wb_rd),
      .i_wdata    (bus.alu_result)
   );

   // ALU-stage registers: load on a legal transfer, otherwise hold; valid is per-cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_instr <= NOP_INSTR;
         r_alu_in1   <= '0;
         r_alu_imm   <= '0;
         r_wb_valid  <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         if (w_xfer && w_legal) begin
            r_alu_instr <= bus.instr_word;
            r_alu_in1   <= w_rs1_val;
            r_alu_imm   <= XLEN'(sext12(w_f.imm12));
            r_wb_valid  <= 1'b1;
         end
      end
   end

   // Illegal pulse and saturating reject counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_illegal <= 1'b0;
         r_ill_cnt <= '0;
      end else begin
         r_illegal <= w_xfer && !w_legal;
         if (w_xfer && !w_legal && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
         end
      end
   end

   assign bus.instr_ready = w_ready;
   assign bus.alu_instr   = r_alu_instr;
   assign bus.alu_in1     = r_alu_in1;
   assign bus.alu_imm     = r_alu_imm;
   assign bus.wb_valid    = r_wb_valid;
   assign bus.wb_rd       = w_wb_rd;
   assign bus.wb_data     = bus.alu_result;
   assign illegal         = r_illegal;
   assign illegal_cnt     = r_ill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_i_type_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i_type_issue
//  Description : Scoreboard bench for i_type_issue with a sequential
//                architectural model and a stand-in ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i_type_issue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        illegal;
   logic [7:0]  illegal_cnt;
   logic [4:0]  dbg_addr = 5'd0;
   logic [31:0] dbg_data;

   i_type_issue_if bus ();

   i_type_issue dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .illegal     (illegal),
      .illegal_cnt (illegal_cnt),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   always #5 clk = ~clk;

   // Stand-in I-type ALU
   function automatic logic [31:0] alu_ref(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] imm);
      case (ins[14:12])
         3'd0: return a + imm;
         3'd1: return a << imm[4:0];
         3'd2: return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
         3'd3: return (a < imm) ? 32'd1 : 32'd0;
         3'd4: return a ^ imm;
         3'd5: return ins[30] ? 32'($signed(a) >>> imm[4:0]) : (a >> imm[4:0]);
         3'd6: return a | imm;
         default: return a & imm;
      endcase
   endfunction

   always_comb bus.alu_result = alu_ref(bus.alu_instr, bus.alu_in1, bus.alu_imm);

   typedef struct {
      bit          legal;
      logic [31:0] instr;
      logic [31:0] in1;
      logic [31:0] imm;
      logic [31:0] res;
      logic [4:0]  rd;
      logic [7:0]  cnt;
      time         t;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mregs [32];
   int          mcnt;
   logic [4:0]  last_rd;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit is_legal(input logic [31:0] w);
      logic [6:0] f7;
      f7 = w[31:25];
      if (w[6:0] != 7'b0010011) return 1'b0;
      if (w[14:12] == 3'd1) return f7 == 7'h00;
      if (w[14:12] == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
   endfunction

   function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] rand_word();
      int         r;
      logic [6:0] op;
      logic [2:0] f3;
      logic [11:0] imm;
      r   = $urandom_range(0, 9);
      f3  = 3'($urandom_range(0, 7));
      imm = 12'($urandom);
      op  = 7'b0010011;
      if (r == 0) begin
         op = 7'($urandom);
         if (op == 7'b0010011) op = 7'b0110011;
      end
      if (f3 == 3'd1) imm[11:5] = (r == 1) ? 7'h01 : 7'h00;
      if (f3 == 3'd5) imm[11:5] = (r == 1) ? 7'h10 : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
      return {imm, 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)), op};
   endfunction

   // Reference model: sequential architectural semantics at acceptance time
   task automatic accept(input logic [31:0] w);
      exp_t e;
      e.t     = $time;
      e.instr = w;
      e.rd    = w[11:7];
      e.legal = is_legal(w);
      e.in1   = 32'd0;
      e.imm   = 32'd0;
      e.res   = 32'd0;
      e.cnt   = 8'd0;
      if (e.legal) begin
         e.in1 = (w[19:15] == 5'd0) ? 32'd0 : mregs[w[19:15]];
         e.imm = 32'($signed(w[31:20]));
         e.res = alu_ref(w, e.in1, e.imm);
         if (e.rd != 5'd0) mregs[e.rd] = e.res;
         last_rd = e.rd;
      end else begin
         if (mcnt < 255) mcnt++;
         e.cnt   = 8'(mcnt);
         last_rd = 5'd0;
      end
      q.push_back(e);
   endtask

   task automatic issue(input logic [31:0] w, output int stalls);
      bit   done;
      bit   rdy;
      logic exp_stall;
      done   = 1'b0;
      stalls = 0;
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr_word  = w;
      for (int k = 0; k < 4 && !done; k++) begin
         #1;
         rdy = bus.instr_ready;
`ifdef I_ISSUE_FORWARD_EN
         exp_stall = 1'b0;
`else
         exp_stall = (last_rd != 5'd0) && (last_rd == w[19:15]);
`endif
         check("instr_ready", 32'(rdy), 32'(!exp_stall));
         @(posedge clk);
         if (rdy) begin
            accept(w);
            done = 1'b1;
         end else begin
            last_rd = 5'd0;
            stalls++;
            @(negedge clk);
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: word %h never accepted, required acceptance", w);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.instr_valid = 1'b0;
         bus.instr_word  = $urandom;
         @(posedge clk);
         last_rd = 5'd0;
      end
   endtask

   task automatic dbg_sweep();
      bus.instr_valid = 1'b0;
      for (int a = 0; a < 32; a++) begin
         dbg_addr = 5'(a);
         #1;
         check($sformatf("dbg_x%0d", a), dbg_data, mregs[a]);
      end
      last_rd = 5'd0;
   endtask

   // Monitor: pop and compare whenever the DUT presents a result
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.wb_valid) begin
               if (q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d, required no output", bus.wb_rd);
               end else begin
                  e = q.pop_front();
                  check("wb_kind_legal", 32'(1), 32'(e.legal));
                  check("wb_latency",    32'($time - e.t), 32'd5);
                  check("alu_instr",     bus.alu_instr, e.instr);
                  check("alu_in1",       bus.alu_in1, e.in1);
                  check("alu_imm",       bus.alu_imm, e.imm);
                  check("wb_rd",         32'(bus.wb_rd), 32'(e.rd));
                  check("wb_data",       bus.wb_data, e.res);
               end
            end
            if (illegal) begin
               if (q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL illegal_unexpected: got illegal=1, required no output");
               end else begin
                  e = q.pop_front();
                  check("illegal_kind", 32'(0), 32'(e.legal));
                  check("illegal_latency", 32'($time - e.t), 32'd5);
                  check("illegal_cnt", 32'(illegal_cnt), 32'(e.cnt));
               end
            end
            while (q.size() > 0 && $time >= q[0].t + 5) begin
               e = q.pop_front();
               checks++; errors++;
               $display("FAIL missing_output: word %h got no wb_valid/illegal, required one", e.instr);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      bus.instr_valid = 1'b0;
      bus.instr_word  = 32'd0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcnt    = 0;
      last_rd = 5'd0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_alu_instr",   bus.alu_instr, 32'h00000013);
      check("rst_alu_in1",     bus.alu_in1, 32'd0);
      check("rst_alu_imm",     bus.alu_imm, 32'd0);
      check("rst_wb_valid",    32'(bus.wb_valid), 32'd0);
      check("rst_illegal",     32'(illegal), 32'd0);
      check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
      rst = 1'b0;
      dbg_sweep();

      // addi x1,x0,-5
      issue(32'hFFB00093, s);
      #2;
      check("x1_alu_imm", bus.alu_imm, 32'hFFFFFFFB);
      check("x1_alu_in1", bus.alu_in1, 32'd0);
      check("x1_wb_rd",   32'(bus.wb_rd), 32'd1);

      // addi x2,x0,7 ; addi x3,x2,1 back to back
      issue(enc(3'd0, 5'd2, 5'd0, 12'd7), s);
      issue(enc(3'd0, 5'd3, 5'd2, 12'd1), s);
`ifdef I_ISSUE_FORWARD_EN
      check("raw_stalls", 32'(s), 32'd0);
`else
      check("raw_stalls", 32'(s), 32'd1);
`endif
      #2;
      check("raw_alu_in1", bus.alu_in1, 32'd7);
      idle(2);
      dbg_addr = 5'd1; #1; check("x1_value", dbg_data, 32'hFFFFFFFB);
      dbg_addr = 5'd3; #1; check("x3_value", dbg_data, 32'd8);

      // addi x0,x0,5 then addi x6,x0,3
      issue(enc(3'd0, 5'd0, 5'd0, 12'd5), s);
      issue(enc(3'd0, 5'd6, 5'd0, 12'd3), s);
      check("x0_stalls", 32'(s), 32'd0);
      #2;
      check("x0_alu_in1", bus.alu_in1, 32'd0);
      idle(2);
      dbg_addr = 5'd0; #1; check("x0_value", dbg_data, 32'd0);
      dbg_addr = 5'd6; #1; check("x6_value", dbg_data, 32'd3);

      // Two illegal words: R-type opcode and slli with bad funct7
      issue(32'h002081B3, s);
      issue({7'b0000001, 5'd3, 5'd1, 3'b001, 5'd4, 7'b0010011}, s);
      idle(2);
      check("illegal_cnt_two", 32'(illegal_cnt), 32'd2);
      dbg_sweep();

      // Randomized traffic with idle gaps
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         issue(rand_word(), s);
      end
      idle(2);
      dbg_sweep();

      // Counter saturation
      repeat (300) issue({25'($urandom), 7'b0110011}, s);
      idle(2);
      check("illegal_cnt_sat", 32'(illegal_cnt), 32'd255);

      // Reset while the ALU stage targets x5
      issue(enc(3'd0, 5'd5, 5'd0, 12'd9), s);
      #2;
      rst = 1'b1;
      #1;
      check("arst_wb_valid",    32'(bus.wb_valid), 32'd0);
      check("arst_alu_instr",   bus.alu_instr, 32'h00000013);
      check("arst_alu_in1",     bus.alu_in1, 32'd0);
      check("arst_alu_imm",     bus.alu_imm, 32'd0);
      check("arst_illegal_cnt", 32'(illegal_cnt), 32'd0);
      q.delete();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcnt    = 0;
      last_rd = 5'd0;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      dbg_addr = 5'd5; #1; check("arst_x5", dbg_data, 32'd0);
      dbg_sweep();

      // Operation resumes after reset
      issue(enc(3'd0, 5'd7, 5'd0, 12'h123), s);
      idle(2);
      dbg_sweep();
      check("queue_empty", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i_type_issue.md
Name: i_type_issue

Overview:
- Producer/consumer end of the I-type ALU interface.
- Accepts 32-bit instruction words over a valid/ready handshake, decodes and validates OP-IMM (opcode 7'b0010011), and reads rs1 from an internal register file.
- Sign-extends imm[11:0], registers {instr, in1, imm} toward the combinational I-type ALU, captures the ALU result and writes it back to rd.
- Forms the decode/regfile/writeback shell of the single-cycle core's OP-IMM path.

Parameters:
XLEN, 32, datapath width (only 32 supported)
REG_COUNT, 32, number of architectural registers; x0 is hard-wired to zero
ILL_CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
instr_valid  input  1  instr_word is valid
instr_ready  output  1  block can accept instr_word this cycle
instr_word  input  32  instruction to issue
alu_instr  output  32  registered instruction to ALU
alu_in1  output  32  registered rs1 operand to ALU
alu_imm  output  32  registered sign-extended immediate to ALU
alu_result  input  32  combinational ALU result for alu_instr/alu_in1/alu_imm
wb_valid  output  1  ALU stage holds an instruction; writeback happens at the end of this cycle
wb_rd  output  5  destination of the ALU-stage instruction
wb_data  output  32  equals alu_result
illegal  output  1  one-cycle pulse, registered, for a rejected instruction
illegal_cnt  output  ILL_CNT_W  saturating count of rejected instructions
dbg_addr  input  5  debug register read address
dbg_data  output  32  combinational read of register dbg_addr; 0 for x0

Behaviour:
- Reset, asynchronous on rst high:
  - all registers x1..x31 = 0
  - alu_instr = 32'h00000013 (addi x0,x0,0)
  - alu_in1 = 0, alu_imm = 0
  - wb_valid = 0, illegal = 0, illegal_cnt = 0
- Reset mid-operation: any in-flight ALU-stage instruction is discarded with no write.
- Handshake: a transfer occurs when instr_valid && instr_ready. instr_word is sampled only on a transfer; the source must hold it while instr_valid is high and instr_ready is low.
- Legality: a transferred word is legal when opcode = 7'b0010011 and:
  - funct3=001 requires instr[31:25]=7'b0000000
  - funct3=101 requires instr[31:25] in {7'b0000000, 7'b0100000}
  - all other funct3 values are legal
- Legal transfer in cycle N:
  - at the end of N: alu_instr <= instr_word, alu_in1 <= rs1 value (after forwarding), alu_imm <= sign-extended instr[31:20], wb_valid <= 1
  - shift instructions pass imm unchanged; the ALU uses imm[4:0] and instr[30]
- Cycle N+1: wb_valid=1, wb_rd=instr[11:7], wb_data=alu_result. At the end of N+1, reg[rd] <= alu_result unless rd=0.
- Latency: one cycle from acceptance to ALU operands; two edges to the architectural write.
- Illegal transfer in cycle N: not issued (wb_valid <= 0 at the end of N), illegal <= 1 for one cycle, illegal_cnt increments and saturates at all-ones.
- No transfer: wb_valid <= 0; the alu_* registers hold their value.
- Throughput: one instruction per cycle. instr_ready = 1 except in a hazard stall (Optional Feature only).
- x0: never written; reads of x0 always return 0, including forwarded reads.
- dbg_data reflects the register file after the last edge and does not include forwarding.

Optional Feature:
- Macro: I_ISSUE_FORWARD_EN.
- Defined: if the accepted instruction's rs1 equals wb_rd, wb_valid=1 and rs1 != 0, then alu_in1 is taken from alu_result. No stall; instr_ready is constantly 1 outside reset.
- Undefined:
  - Under the same condition instr_ready = 0 for one cycle (RAW stall).
  - The instruction is accepted the following cycle, reading the written-back value from the register file.
  - The stall cycle produces wb_valid=0 next cycle.
  - instr_ready is combinational from instr_word and the ALU-stage state.

Decomposition:
- Package i_issue_pkg:
  - OPCODE_OP_IMM = 7'b0010011
  - NOP_INSTR = 32'h00000013
  - funct3 enum: ADDI, SLLI, SLTI, SLTIU, XORI, SRLI_SRAI, ORI, ANDI
  - FUNCT7_ZERO, FUNCT7_SRA
  - typedef i_fields_t {imm12, rs1, funct3, rd, opcode}
- Sub-module i_issue_regfile: REG_COUNT x XLEN register file.
  - Two combinational read ports: rs1 and dbg.
  - One synchronous write port, gated against x0.
  - Asynchronous reset to 0.
- The top level holds decode, legality check, forwarding/stall logic, ALU-stage registers and the illegal counter.

Test Plan:
- Reset, then read dbg_addr 0..31 -> all 0; alu_instr=32'h00000013, wb_valid=0, illegal_cnt=0.
- Issue addi x1,x0,-5 (32'hFFB00093) with alu_result driven by a reference model -> next cycle alu_imm=32'hFFFFFFFB, alu_in1=0, wb_rd=1; afterwards dbg reg1=32'hFFFFFFFB.
- Back-to-back addi x2,x0,7 then addi x3,x2,1:
  - with I_ISSUE_FORWARD_EN: alu_in1=7 for the second instruction, no stall, reg3=8
  - without: instr_ready=0 for exactly one cycle, then reg3=8
- Issue addi x0,x0,5 and an instruction with rs1=x0 behind it -> reg0 stays 0, no forwarding from x0, no stall.
- Issue opcode 7'b0110011 and slli with instr[31:25]=7'b0000001 -> illegal pulses twice, illegal_cnt=2, no register changes. Issue 300 illegal words -> illegal_cnt=255.
- Assert rst while wb_valid=1 targeting x5 -> x5 remains 0, all outputs return to reset values asynchronously.
